video_timing_decoder: RTL and testbench

Receive-side counterpart of the core's raster generator. It samples the blanking and sync strobes, qualified by the pixel clock enable, and rebuilds pixel/line coordinates and a data-enable. Each frame it measures line length, frame length and active area, and raises a lock flag once two consecutive complete frames agree. It sits between the core's video outputs and downstream consumers (capture, overlay, diagnostics) that need coordinates without access to the generator's internal counters.

---
 rtl/video_timing_decoder.sv | 107 ++++++++++
 tb/tb_video_timing_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_decoder.sv
// video_timing_decoder: rebuilds pixel/line coordinates from blank/sync strobes, measures the raster and reports lock.
module video_timing_decoder #(
  parameter int TIMEOUT = 1023
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       HBLK,
  input  logic       VBLK,
  input  logic       HSYN,
  input  logic       VSYN,
  output logic [8:0] PX,
  output logic [8:0] PY,
  output logic       DE,
  output logic       FRAME,
  output logic [9:0] H_TOTAL,
  output logic [9:0] V_TOTAL,
  output logic [9:0] ACT_W,
  output logic [9:0] ACT_H,
  output logic       LOCKED
);
  typedef enum logic [1:0] {SEARCH, FIRST, MEASURE, LOCK} state_t;
  localparam logic [9:0] TO = 10'(TIMEOUT);
  function automatic logic [9:0] sat_inc(input logic [9:0] x);
    return (&x) ? x : x + 10'd1;
  endfunction
  state_t      r_state;
  logic        r_hb_q, r_hs_q, r_vs_q;
  logic [8:0]  r_px_cnt, r_ln_cnt;
  logic [9:0]  r_h_cnt, r_h_len, r_aw_cnt, r_aw_len, r_v_cnt, r_ah_cnt;
  logic [39:0] r_prev;
  logic        w_de, w_hb_rise, w_hs_fall, w_vs_fall, w_to;
  logic [9:0]  w_h_len, w_aw_len, w_v_cnt, w_ah_cnt, w_h_cnt_nxt, w_v_cnt_nxt;
  logic [39:0] w_snap;
  // a same-tick HSYN fall or HBLK rise belongs to the frame that the VSYN fall closes
  always_comb begin
    w_de        = ~HBLK & ~VBLK;
    w_hb_rise   = ~r_hb_q & HBLK & ~VBLK;
    w_hs_fall   = r_hs_q & ~HSYN;
    w_vs_fall   = r_vs_q & ~VSYN;
    w_h_len     = w_hs_fall ? sat_inc(r_h_cnt) : r_h_len;
    w_aw_len    = w_hb_rise ? r_aw_cnt : r_aw_len;
    w_v_cnt     = w_hs_fall ? sat_inc(r_v_cnt) : r_v_cnt;
    w_ah_cnt    = w_hb_rise ? sat_inc(r_ah_cnt) : r_ah_cnt;
    w_snap      = {w_h_len, w_aw_len, w_v_cnt, w_ah_cnt};
    w_h_cnt_nxt = w_hs_fall ? 10'd0 : sat_inc(r_h_cnt);
    w_v_cnt_nxt = w_vs_fall ? 10'd0 : w_v_cnt;
    w_to        = (w_h_cnt_nxt >= TO) | (w_v_cnt_nxt >= TO);
  end
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= SEARCH;
      r_hb_q   <= 1'b1;
      r_hs_q   <= 1'b1;
      r_vs_q   <= 1'b1;
      r_px_cnt <= '0;
      r_ln_cnt <= '0;
      r_h_cnt  <= '0;
      r_h_len  <= '0;
      r_aw_cnt <= '0;
      r_aw_len <= '0;
      r_v_cnt  <= '0;
      r_ah_cnt <= '0;
      r_prev   <= '0;
      PX       <= '0;
      PY       <= '0;
      DE       <= 1'b0;
      FRAME    <= 1'b0;
      H_TOTAL  <= '0;
      V_TOTAL  <= '0;
      ACT_W    <= '0;
      ACT_H    <= '0;
      LOCKED   <= 1'b0;
    end else begin
      FRAME <= CE & w_vs_fall;
      if (CE) begin
        r_hb_q   <= HBLK;
        r_hs_q   <= HSYN;
        r_vs_q   <= VSYN;
        DE       <= w_de;
        if (w_de) begin
          PX <= r_px_cnt;
          PY <= r_ln_cnt;
        end
        r_px_cnt <= HBLK ? 9'd0 : w_de ? r_px_cnt + 9'd1 : r_px_cnt;
        r_ln_cnt <= VBLK ? 9'd0 : w_hb_rise ? r_ln_cnt + 9'd1 : r_ln_cnt;
        r_h_cnt  <= w_h_cnt_nxt;
        r_h_len  <= w_h_len;
        r_aw_cnt <= w_hb_rise ? 10'd0 : w_de ? sat_inc(r_aw_cnt) : r_aw_cnt;
        r_aw_len <= w_aw_len;
        r_v_cnt  <= w_v_cnt_nxt;
        r_ah_cnt <= w_vs_fall ? 10'd0 : w_ah_cnt;
        if (w_vs_fall)
          {H_TOTAL, ACT_W, V_TOTAL, ACT_H} <= w_snap;
        if (w_to) begin
          r_state <= SEARCH;
          LOCKED  <= 1'b0;
        end else if (w_vs_fall) begin
          if (r_state != SEARCH)
            r_prev <= w_snap;
          r_state <= (r_state == SEARCH) ? FIRST : (r_state == FIRST) ? MEASURE : (w_snap == r_prev) ? LOCK : MEASURE;
          LOCKED  <= (r_state == MEASURE || r_state == LOCK) && (w_snap == r_prev);
        end
      end
    end
  end
endmodule

// File: tb/tb_video_timing_decoder.sv
// tb_video_timing_decoder: random-CE raster stimulus checked each cycle against an event-count model, plus literal pins.
module tb_video_timing_decoder;
  localparam int TO = 1023;
  logic MCLK = 0, RESET = 1, CE = 0, HBLK = 1, VBLK = 1, HSYN = 1, VSYN = 1;
  logic [8:0] PX, PY;
  logic DE, FRAME, LOCKED;
  logic [9:0] H_TOTAL, V_TOTAL, ACT_W, ACT_H;

  video_timing_decoder #(.TIMEOUT(TO)) dut (
    .MCLK(MCLK), .RESET(RESET), .CE(CE), .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
    .PX(PX), .PY(PY), .DE(DE), .FRAME(FRAME), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .ACT_W(ACT_W), .ACT_H(ACT_H), .LOCKED(LOCKED)
  );

  always #5 MCLK = ~MCLK;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 20) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // raster generator: active part first in each line/frame, syncs inside blanking
  int L, AW, V, AH, nL, nAW, nV, nAH, x, y, ce_mode, cyc;
  bit hs_en;

  task automatic drive_cycle();
    @(posedge MCLK);
    #1;
    cyc++;
    CE = (ce_mode == 0) || (ce_mode == 1 && $urandom_range(0, 1) == 1) || (ce_mode == 2 && cyc % 4 == 0);
    if (CE) begin
      HBLK = (x >= AW);
      VBLK = (y >= AH);
      HSYN = !(hs_en && x >= AW + 4 && x < AW + 12);
      VSYN = !(y >= AH + 3 && y < AH + 6);
      x++;
      if (x == L) begin
        x = 0;
        y++;
        if (y == V) begin
          y = 0;
          L = nL; AW = nAW; V = nV; AH = nAH;
        end
      end
    end
  endtask

  task automatic set_geom(input int l, input int aw, input int v, input int ah);
    nL = l; nAW = aw; nV = v; nAH = ah;
  endtask

  // model: outputs derived from running totals of sampled events
  int k, hsl, de_tot, de_hb, ri_tot, ri_vb, de_ri, ri_vs, hsf_tot, hsf_vs, h_m, aw_m, nvs, m_vsf;
  int e_px, e_py, e_de, e_frame, e_ht, e_aw, e_vt, e_ah, e_lock;
  bit hb_p, hs_p, vs_p;
  logic [39:0] prev;

  function automatic int sat(input int v);
    return v > 1023 ? 1023 : v;
  endfunction

  task automatic m_init();
    k = 0; hsl = -1; de_tot = 0; de_hb = 0; ri_tot = 0; ri_vb = 0; de_ri = 0; ri_vs = 0;
    hsf_tot = 0; hsf_vs = 0; h_m = 0; aw_m = 0; nvs = 0; m_vsf = 0; prev = '0;
    e_px = 0; e_py = 0; e_de = 0; e_frame = 0; e_ht = 0; e_aw = 0; e_vt = 0; e_ah = 0; e_lock = 0;
    hb_p = 1; hs_p = 1; vs_p = 1;
  endtask

  task automatic m_tick();
    bit de, rise, hsf, vsf, to;
    logic [39:0] snap;
    snap = '0;
    de   = !HBLK && !VBLK;
    rise = !hb_p && HBLK && !VBLK;
    hsf  = hs_p && !HSYN;
    vsf  = vs_p && !VSYN;
    if (de) begin
      e_px = (de_tot - de_hb) % 512;
      e_py = (ri_tot - ri_vb) % 512;
      de_tot++;
    end
    if (HBLK) de_hb = de_tot;
    if (VBLK) ri_vb = ri_tot;
    if (rise) begin
      aw_m = sat(de_tot - de_ri);
      de_ri = de_tot;
      ri_tot++;
    end
    if (hsf) begin
      h_m = sat(k - hsl);
      hsl = k;
      hsf_tot++;
    end
    e_de = int'(de);
    e_frame = int'(vsf);
    if (vsf) begin
      snap = {10'(h_m), 10'(aw_m), 10'(sat(hsf_tot - hsf_vs)), 10'(sat(ri_tot - ri_vs))};
      e_ht = h_m; e_aw = aw_m; e_vt = sat(hsf_tot - hsf_vs); e_ah = sat(ri_tot - ri_vs);
      hsf_vs = hsf_tot; ri_vs = ri_tot; m_vsf++;
    end
    to = (k - hsl >= TO) || (hsf_tot - hsf_vs >= TO);
    if (to) begin
      nvs = 0;
      e_lock = 0;
    end else if (vsf) begin
      nvs++;
      e_lock = int'(nvs >= 3 && snap == prev);
      prev = snap;
    end
    hb_p = HBLK; hs_p = HSYN; vs_p = VSYN;
    k++;
  endtask

  initial begin
    m_init();
    forever begin
      @(posedge MCLK or posedge RESET);
      if (RESET) m_init();
      else begin
        e_frame = 0;
        if (CE) m_tick();
      end
    end
  end

  int mx_px, mx_py, n_frame;
  initial begin
    mx_px = 0; mx_py = 0; n_frame = 0;
    forever begin
      @(negedge MCLK);
      chk("DE", int'(DE), e_de);
      chk("PX", int'(PX), e_px);
      chk("PY", int'(PY), e_py);
      chk("FRAME", int'(FRAME), e_frame);
      chk("H_TOTAL", int'(H_TOTAL), e_ht);
      chk("ACT_W", int'(ACT_W), e_aw);
      chk("V_TOTAL", int'(V_TOTAL), e_vt);
      chk("ACT_H", int'(ACT_H), e_ah);
      chk("LOCKED", int'(LOCKED), e_lock);
      if (DE && int'(PX) > mx_px) mx_px = int'(PX);
      if (DE && int'(PY) > mx_py) mx_py = int'(PY);
      if (FRAME) n_frame++;
    end
  end

  task automatic run_until_vsf(input int target);
    int g = 0;
    while (m_vsf < target && g < 50000) begin
      drive_cycle();
      g++;
    end
    if (m_vsf < target) chk("vsf_wait_expired", m_vsf, target);
  endtask

  task automatic wait_y1();
    int g = 0;
    while (y == 1 && g < 20000) begin drive_cycle(); g++; end
    while (y != 1 && g < 20000) begin drive_cycle(); g++; end
    if (y != 1) chk("line_wait_expired", y, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_PX"}, int'(PX), 0);
    chk({nm, "_PY"}, int'(PY), 0);
    chk({nm, "_DE"}, int'(DE), 0);
    chk({nm, "_FRAME"}, int'(FRAME), 0);
    chk({nm, "_H_TOTAL"}, int'(H_TOTAL), 0);
    chk({nm, "_V_TOTAL"}, int'(V_TOTAL), 0);
    chk({nm, "_ACT_W"}, int'(ACT_W), 0);
    chk({nm, "_ACT_H"}, int'(ACT_H), 0);
    chk({nm, "_LOCKED"}, int'(LOCKED), 0);
  endtask

  initial begin
    set_geom(40, 29, 20, 14);
    L = 40; AW = 29; V = 20; AH = 14; x = 0; y = 0; hs_en = 1; ce_mode = 0; cyc = 0;
    repeat (3) @(posedge MCLK);
    #1;
    chk_zero("reset");
    #2 RESET = 0;
    // nominal raster, CE every cycle
    run_until_vsf(3);
    chk("nom_H_TOTAL", int'(H_TOTAL), 40);
    chk("nom_ACT_W", int'(ACT_W), 29);
    chk("nom_V_TOTAL", int'(V_TOTAL), 20);
    chk("nom_ACT_H", int'(ACT_H), 14);
    chk("nom_LOCKED", int'(LOCKED), 1);
    drive_cycle();
    chk("nom_max_PX", mx_px, 28);
    chk("nom_max_PY", mx_py, 13);
    chk("nom_frames", n_frame, 3);
    // sparse CE
    ce_mode = 2;
    run_until_vsf(5);
    chk("ce4_LOCKED", int'(LOCKED), 1);
    chk("ce4_H_TOTAL", int'(H_TOTAL), 40);
    // one frame of 41-tick lines
    ce_mode = 0;
    set_geom(41, 29, 20, 14);
    wait_y1();
    set_geom(40, 29, 20, 14);
    run_until_vsf(6);
    chk("chg_LOCKED", int'(LOCKED), 0);
    chk("chg_H_TOTAL", int'(H_TOTAL), 41);
    run_until_vsf(7);
    chk("rest1_LOCKED", int'(LOCKED), 0);
    chk("rest1_H_TOTAL", int'(H_TOTAL), 40);
    run_until_vsf(8);
    chk("rest2_LOCKED", int'(LOCKED), 1);
    // random CE and random geometry, repeated in pairs so lock can be reached
    ce_mode = 1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        int aw, ah;
        aw = $urandom_range(10, 30);
        ah = $urandom_range(5, 15);
        set_geom(aw + $urandom_range(13, 25), aw, ah + $urandom_range(7, 12), ah);
      end
      wait_y1();
    end
    set_geom(40, 29, 20, 14);
    run_until_vsf(m_vsf + 5);
    chk("relock_LOCKED", int'(LOCKED), 1);
    // sync loss
    ce_mode = 0;
    hs_en = 0;
    for (int i = 0; i < 1100; i++) drive_cycle();
    chk("syncloss_LOCKED", int'(LOCKED), 0);
    hs_en = 1;
    run_until_vsf(m_vsf + 4);
    chk("syncback_LOCKED", int'(LOCKED), 1);
    // asynchronous reset mid-line, then restart mid-frame
    begin
      int g = 0;
      while (x != 10 && g < 1000) begin drive_cycle(); g++; end
    end
    #2;
    CE = 0;
    RESET = 1;
    #1;
    chk_zero("async_reset");
    repeat (3) @(posedge MCLK);
    x = 0; y = 5; L = 40; AW = 29; V = 20; AH = 14;
    #3 RESET = 0;
    run_until_vsf(1);
    chk("partial1_LOCKED", int'(LOCKED), 0);
    run_until_vsf(2);
    chk("partial2_LOCKED", int'(LOCKED), 0);
    run_until_vsf(3);
    chk("partial3_LOCKED", int'(LOCKED), 1);
    chk("partial3_V_TOTAL", int'(V_TOTAL), 20);
    repeat (3) drive_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
